// File: rtl/up_down_counter.sv
// up_down_counter: N-bit synchronous up/down counter with enable, terminal count and wrap pulse.
// Define UP_DOWN_COUNTER_SAT_EN to make the counter saturate at its limits instead of wrapping.
`default_nettype none

module up_down_counter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         up_down,
   output logic [N-1:0] count,
   output logic         tc,
   output logic         wrap
);

   localparam logic [N-1:0] MAX_COUNT = {N{1'b1}};

   logic at_max;
   logic at_zero;
   logic [N-1:0] count_inc;
   logic [N-1:0] count_dec;

   assign at_max    = (count == MAX_COUNT);
   assign at_zero   = (count == '0);
   assign count_inc = count + {{(N-1){1'b0}}, 1'b1};
   assign count_dec = count - {{(N-1){1'b0}}, 1'b1};

   // tc looks one edge ahead: it is high exactly when the next enabled edge crosses a limit.
   assign tc = enable & (up_down ? at_max : at_zero);

`ifdef UP_DOWN_COUNTER_SAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (enable && !tc) begin
         count <= up_down ? count_inc : count_dec;
      end
      wrap <= 1'b0;
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         wrap  <= 1'b0;
      end else if (enable) begin
         count <= up_down ? count_inc : count_dec;
         wrap  <= tc;
      end else begin
         wrap  <= 1'b0;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter against an arithmetic reference model.
`default_nettype none

module tb_up_down_counter;

   localparam int N    = 4;
   localparam int MAXV = (1 << N) - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         enable = 1'b0;
   logic         up_down = 1'b0;
   logic [N-1:0] count;
   logic         tc;
   logic         wrap;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int m_count = 0;
   bit m_wrap  = 1'b0;

   up_down_counter #(.N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .up_down (up_down),
      .count   (count),
      .tc      (tc),
      .wrap    (wrap)
   );

   always #5 clk = ~clk;

   function automatic bit exp_tc();
      return enable && ((up_down && m_count == MAXV) || (!up_down && m_count == 0));
   endfunction

   task automatic set_inputs(input bit en, input bit ud, input bit rs);
      @(negedge clk);
      enable  = en;
      up_down = ud;
      rst     = rs;
      #1;
   endtask

   // Advance one rising edge and apply the counting rules to the model.
   task automatic clock_edge();
      int nxt;
      @(posedge clk);
      if (rst) begin
         m_count = 0;
         m_wrap  = 1'b0;
      end else if (enable) begin
         nxt = up_down ? m_count + 1 : m_count - 1;
         if (nxt > MAXV || nxt < 0) begin
`ifdef UP_DOWN_COUNTER_SAT_EN
            m_wrap = 1'b0;
`else
            m_count = (nxt + (MAXV + 1)) % (MAXV + 1);
            m_wrap  = 1'b1;
`endif
         end else begin
            m_count = nxt;
            m_wrap  = 1'b0;
         end
      end else begin
         m_wrap = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      set_inputs(1, 1, 1);
      clock_edge();
      checks++;
      if (count !== 4'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d expected 0", count);
      end
      checks++;
      if (wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_wrap: got %b expected 0", wrap);
      end
      checks++;
      if (tc !== 1'b0) begin
         errors++;
         $display("FAIL reset_tc: got %b expected 0", tc);
      end
   endtask

   task automatic test_up_down();
      set_inputs(1, 1, 0);
      for (int i = 1; i <= 10; i++) begin
         clock_edge();
         checks++;
         if (count !== m_count[N-1:0] || m_count != i) begin
            errors++;
            $display("FAIL up_step%0d: got %0d expected %0d", i, count, i);
         end
      end
      set_inputs(1, 0, 0);
      for (int i = 9; i >= 0; i--) begin
         clock_edge();
         checks++;
         if (count !== m_count[N-1:0] || m_count != i) begin
            errors++;
            $display("FAIL down_step%0d: got %0d expected %0d", i, count, i);
         end
      end
      set_inputs(0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         clock_edge();
         checks++;
         if (count !== 4'd0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL hold%0d: got count=%0d wrap=%b expected count=0 wrap=0", i, count, wrap);
         end
      end
   endtask

   task automatic test_up_wrap();
      set_inputs(1, 1, 1);
      clock_edge();
      set_inputs(1, 1, 0);
      for (int i = 0; i < 14; i++) clock_edge();
      checks++;
      if (count !== 4'd14 || tc !== 1'b0) begin
         errors++;
         $display("FAIL upwrap_14: got count=%0d tc=%b expected count=14 tc=0", count, tc);
      end
      clock_edge();
      checks++;
      if (count !== 4'd15 || tc !== 1'b1 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL upwrap_15: got count=%0d tc=%b wrap=%b expected 15 1 0", count, tc, wrap);
      end
      clock_edge();
`ifndef UP_DOWN_COUNTER_SAT_EN
      checks++;
      if (count !== 4'd0 || wrap !== 1'b1) begin
         errors++;
         $display("FAIL upwrap_0: got count=%0d wrap=%b expected 0 1", count, wrap);
      end
      clock_edge();
      checks++;
      if (count !== 4'd1 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL upwrap_1: got count=%0d wrap=%b expected 1 0", count, wrap);
      end
`endif
      checks++;
      if (count !== m_count[N-1:0] || wrap !== m_wrap) begin
         errors++;
         $display("FAIL upwrap_model: got count=%0d wrap=%b expected %0d %b", count, wrap, m_count, m_wrap);
      end
   endtask

   task automatic test_down_wrap();
      set_inputs(1, 0, 1);
      clock_edge();
      set_inputs(1, 0, 0);
      checks++;
      if (tc !== 1'b1) begin
         errors++;
         $display("FAIL downwrap_tc: got %b expected 1", tc);
      end
      clock_edge();
      checks++;
      if (count !== m_count[N-1:0] || wrap !== m_wrap) begin
         errors++;
         $display("FAIL downwrap: got count=%0d wrap=%b expected %0d %b", count, wrap, m_count, m_wrap);
      end
      set_inputs(0, 0, 0);
      clock_edge();
      checks++;
      if (wrap !== 1'b0) begin
         errors++;
         $display("FAIL downwrap_pulse: got wrap=%b expected 0", wrap);
      end
   endtask

   task automatic test_reset_mid();
      set_inputs(1, 1, 1);
      clock_edge();
      set_inputs(1, 1, 0);
      for (int i = 0; i < 7; i++) clock_edge();
      set_inputs(1, 1, 1);
      clock_edge();
      checks++;
      if (count !== 4'd0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL midreset: got count=%0d wrap=%b expected 0 0", count, wrap);
      end
      set_inputs(1, 1, 0);
      clock_edge();
      checks++;
      if (count !== 4'd1) begin
         errors++;
         $display("FAIL midreset_resume: got %0d expected 1", count);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         set_inputs(($urandom_range(0, 9) < 7), $urandom_range(0, 1), ($urandom_range(0, 39) == 0));
         checks++;
         if (tc !== exp_tc()) begin
            errors++;
            $display("FAIL rand_tc%0d: got %b expected %b", i, tc, exp_tc());
         end
         clock_edge();
         checks++;
         if (count !== m_count[N-1:0] || wrap !== m_wrap) begin
            errors++;
            $display("FAIL rand_state%0d: got count=%0d wrap=%b expected %0d %b", i, count, wrap, m_count, m_wrap);
         end
      end
   endtask

`ifdef UP_DOWN_COUNTER_SAT_EN
   task automatic test_saturate();
      int exp_seq[5] = '{14, 15, 15, 15, 15};
      set_inputs(1, 1, 1);
      clock_edge();
      set_inputs(1, 1, 0);
      for (int i = 0; i < 13; i++) clock_edge();
      for (int i = 0; i < 5; i++) begin
         clock_edge();
         checks++;
         if (count !== exp_seq[i][N-1:0] || wrap !== 1'b0 || tc !== (exp_seq[i] == 15)) begin
            errors++;
            $display("FAIL sat%0d: got count=%0d wrap=%b tc=%b expected %0d 0 %b",
                     i, count, wrap, tc, exp_seq[i], (exp_seq[i] == 15));
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_up_down();
      test_up_wrap();
      test_down_wrap();
      test_reset_mid();
`ifdef UP_DOWN_COUNTER_SAT_EN
      test_saturate();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
